// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the program-counter unit and its return-address
//   stack. It holds the default parameter constants and the next-PC select
//   enumeration. The enumeration is listed from highest to lowest priority.
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int          DEF_WIDTH     = 16;
    localparam int unsigned DEF_INC       = 1;
    localparam int unsigned DEF_RESET_VEC = 32'h0000_0000;
    localparam int unsigned DEF_EXC_VEC   = 32'h0000_0000;
    localparam int          DEF_RAS_DEPTH = 4;

    // Next-PC source, highest priority first.
    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_HOLD,
        SEL_ERET,
        SEL_RET,
        SEL_JUMP,
        SEL_BR,
        SEL_SEQ
    } pc_sel_e;

endpackage : pc_pkg

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
//   Return-address stack built as a circular buffer. A push writes at the
//   write pointer and advances it. A pop steps the pointer back. The entry
//   count saturates at DEPTH. When the stack is full, a push therefore
//   overwrites the oldest entry while the newest entries stay reachable in
//   LIFO order.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (pointer and count only)
//   push       : write push_data as the new top entry
//   pop        : discard the top entry (ignored when empty)
//   push_data  : [WIDTH] address to push
//   top        : [WIDTH] current top entry (don't-care when empty)
//   empty      : no entries held
//   full       : DEPTH entries held
//
// The caller never raises push and pop together. If that happens, push wins.
// ---------------------------------------------------------------------------
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] entry_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count_reg;

    // Entry storage is deliberately not reset. Contents only matter once
    // they have been written by a push.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // DEPTH is a power of two, so the pointer arithmetic wraps naturally.
    assign top_ptr = wr_ptr_reg - 1'b1;
    assign top     = entry_reg[top_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (count_reg != CNT_MAX) begin
                count_reg <= count_reg + 1'b1;
            end
        end else if (pop && (count_reg != '0)) begin
            wr_ptr_reg <= wr_ptr_reg - 1'b1;
            count_reg  <= count_reg - 1'b1;
        end
    end

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_MAX);

endmodule : pc_ras

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program-counter unit. It selects the next PC from exceptions, stalls,
//   exception return, subroutine return, jumps/calls, branches and the
//   sequential increment. It keeps a saved exception PC (epc) and a
//   return-address stack.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   stall          : hold pc, epc and stack (an exception still acts)
//   branch_taken   : redirect to branch_target
//   branch_target  : [WIDTH] branch destination
//   jump           : redirect to jump_target
//   call           : with jump, also push pc+INC
//   jump_target    : [WIDTH] jump/call destination
//   ret            : pop the stack top into pc
//   exc_req        : take the exception, saving pc into epc
//   eret           : return to epc
//   pc             : [WIDTH] current program counter (registered)
//   epc            : [WIDTH] saved exception PC
//   ras_empty      : stack empty
//   ras_full       : stack full
//   ras_err        : one-cycle pulse after a ret on an empty stack
//
// Only one request acts per cycle. Lower-priority requests, including a call
// push, have no side effects.
// ---------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int                 WIDTH     = DEF_WIDTH,
    parameter int unsigned        INC       = DEF_INC,
    parameter logic [WIDTH-1:0]   RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0]   EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int                 RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    pc_sel_e          sel;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc_reg;
    logic [WIDTH-1:0] epc_next;
    logic             ras_err_reg;
    logic             ras_err_next;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_push;
    logic             ras_pop;

    // Modulo-2^WIDTH increment. Wrap-around is silent.
    assign seq_pc = pc_reg + WIDTH'(INC);

    // Priority select. Exceptions win even over a stall.
    always_comb begin
        sel = SEL_SEQ;
        if (exc_req) begin
            sel = SEL_EXC;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (eret) begin
            sel = SEL_ERET;
        end else if (ret) begin
            sel = SEL_RET;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_next      = pc_reg;
        epc_next     = epc_reg;
        ras_err_next = 1'b0;
        ras_push     = 1'b0;
        ras_pop      = 1'b0;
        case (sel)
            SEL_EXC: begin
                pc_next  = EXC_VEC;
                epc_next = pc_reg;
            end
            SEL_HOLD: begin
                pc_next = pc_reg;
            end
            SEL_ERET: begin
                pc_next = epc_reg;
            end
            SEL_RET: begin
                // A return with nothing to return to is treated as a fault.
                // The unit traps to the handler and records where it happened.
                if (ras_empty) begin
                    pc_next      = EXC_VEC;
                    epc_next     = pc_reg;
                    ras_err_next = 1'b1;
                end else begin
                    pc_next = ras_top;
                    ras_pop = 1'b1;
                end
            end
            SEL_JUMP: begin
                pc_next  = jump_target;
                ras_push = call;
            end
            SEL_BR: begin
                pc_next = branch_target;
            end
            default: begin
                pc_next = seq_pc;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg      <= RESET_VEC;
            epc_reg     <= RESET_VEC;
            ras_err_reg <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            epc_reg     <= epc_next;
            ras_err_reg <= ras_err_next;
        end
    end

    // The return address is the sequential successor of the calling PC.
    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign pc      = pc_reg;
    assign epc     = epc_reg;
    assign ras_err = ras_err_reg;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//   Directed-vector bench for pc_unit with default parameters (WIDTH=16,
//   INC=1, RESET_VEC=0, EXC_VEC=0, RAS_DEPTH=4). The driver issues one
//   request per cycle and queues the hand-computed state expected after it.
//   A monitor pops and compares on every falling edge, and also shortly after
//   a rising reset.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam logic [6:0] ST = 7'b100_0000;
    localparam logic [6:0] EX = 7'b010_0000;
    localparam logic [6:0] ER = 7'b001_0000;
    localparam logic [6:0] RT = 7'b000_1000;
    localparam logic [6:0] JP = 7'b000_0100;
    localparam logic [6:0] CL = 7'b000_0010;
    localparam logic [6:0] BR = 7'b000_0001;

    typedef struct {
        string       name;
        logic [15:0] pc;
        logic [15:0] epc;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic        call;
    logic [15:0] jump_target;
    logic        ret;
    logic        exc_req;
    logic        eret;
    logic [15:0] pc;
    logic [15:0] epc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .exc_req       (exc_req),
        .eret          (eret),
        .pc            (pc),
        .epc           (epc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_err       (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_inputs(input logic [6:0] ctl, input logic [15:0] jt, input logic [15:0] bt);
        stall         = ctl[6];
        exc_req       = ctl[5];
        eret          = ctl[4];
        ret           = ctl[3];
        jump          = ctl[2];
        call          = ctl[1];
        branch_taken  = ctl[0];
        jump_target   = jt;
        branch_target = bt;
    endtask

    task automatic push_exp(input string name, input logic [15:0] e_pc, input logic [15:0] e_epc,
                            input logic e_empty, input logic e_full, input logic e_err);
        exp_t e;
        e.name  = name;
        e.pc    = e_pc;
        e.epc   = e_epc;
        e.empty = e_empty;
        e.full  = e_full;
        e.err   = e_err;
        exp_q.push_back(e);
    endtask

    // Drives one request in front of the next rising edge. After that edge it
    // queues the expected post-edge state.
    task automatic cycle(input string name, input logic [6:0] ctl, input logic [15:0] jt,
                         input logic [15:0] bt, input logic [15:0] e_pc, input logic [15:0] e_epc,
                         input logic e_empty, input logic e_full, input logic e_err);
        set_inputs(ctl, jt, bt);
        @(posedge clk);
        push_exp(name, e_pc, e_epc, e_empty, e_full, e_err);
        #1;
    endtask

    // Monitor: compares one queued expectation per sampling point.
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if ({pc, epc, ras_empty, ras_full, ras_err} !== {e.pc, e.epc, e.empty, e.full, e.err}) begin
                    miscompares++;
                    $display("FAIL %s: got pc=%h epc=%h empty=%b full=%b err=%b, expected pc=%h epc=%h empty=%b full=%b err=%b",
                             e.name, pc, epc, ras_empty, ras_full, ras_err,
                             e.pc, e.epc, e.empty, e.full, e.err);
                end else begin
                    $display("ok   %-12s pc=%h epc=%h empty=%b full=%b err=%b",
                             e.name, pc, epc, ras_empty, ras_full, ras_err);
                end
            end
        end
    end

    // Watchdog so that the run cannot hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        set_inputs(7'b0, 16'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        push_exp("reset", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b0;

        // Free-running increment after reset.
        cycle("seq1",       7'b0,     16'h0000, 16'h0000, 16'h0001, 16'h0000, 1, 0, 0);
        cycle("seq2",       7'b0,     16'h0000, 16'h0000, 16'h0002, 16'h0000, 1, 0, 0);
        cycle("seq3",       7'b0,     16'h0000, 16'h0000, 16'h0003, 16'h0000, 1, 0, 0);
        // Single call and return.
        cycle("jump10",     JP,       16'h0010, 16'h0000, 16'h0010, 16'h0000, 1, 0, 0);
        cycle("call100",    JP|CL,    16'h0100, 16'h0000, 16'h0100, 16'h0000, 0, 0, 0);
        cycle("seq101",     7'b0,     16'h0000, 16'h0000, 16'h0101, 16'h0000, 0, 0, 0);
        cycle("seq102",     7'b0,     16'h0000, 16'h0000, 16'h0102, 16'h0000, 0, 0, 0);
        cycle("ret11",      RT,       16'h0000, 16'h0000, 16'h0011, 16'h0000, 1, 0, 0);
        // A stall suppresses the call and its push.
        cycle("stall_call", ST|JP|CL, 16'h0200, 16'h0000, 16'h0011, 16'h0000, 1, 0, 0);
        // Five nested calls into a 4-deep stack.
        cycle("call1",      JP|CL,    16'h0200, 16'h0000, 16'h0200, 16'h0000, 0, 0, 0);
        cycle("call2",      JP|CL,    16'h0300, 16'h0000, 16'h0300, 16'h0000, 0, 0, 0);
        cycle("call3",      JP|CL,    16'h0400, 16'h0000, 16'h0400, 16'h0000, 0, 0, 0);
        cycle("call4",      JP|CL,    16'h0500, 16'h0000, 16'h0500, 16'h0000, 0, 1, 0);
        cycle("call5",      JP|CL,    16'h0600, 16'h0000, 16'h0600, 16'h0000, 0, 1, 0);
        cycle("ret1",       RT,       16'h0000, 16'h0000, 16'h0501, 16'h0000, 0, 0, 0);
        cycle("ret2",       RT,       16'h0000, 16'h0000, 16'h0401, 16'h0000, 0, 0, 0);
        cycle("ret3",       RT,       16'h0000, 16'h0000, 16'h0301, 16'h0000, 0, 0, 0);
        cycle("ret4",       RT,       16'h0000, 16'h0000, 16'h0201, 16'h0000, 1, 0, 0);
        // Return on an empty stack. The call in the same cycle must not push.
        cycle("ret5_empty", RT|JP|CL, 16'h0700, 16'h0000, 16'h0000, 16'h0201, 1, 0, 1);
        cycle("err_clear",  7'b0,     16'h0000, 16'h0000, 16'h0001, 16'h0201, 1, 0, 0);
        // An exception overrides a stall, and eret restores the saved PC.
        cycle("branch40",   BR,       16'h0000, 16'h0040, 16'h0040, 16'h0201, 1, 0, 0);
        cycle("stall_exc",  ST|EX,    16'h0000, 16'h0000, 16'h0000, 16'h0040, 1, 0, 0);
        cycle("stall_eret", ST|ER,    16'h0000, 16'h0000, 16'h0000, 16'h0040, 1, 0, 0);
        cycle("eret",       ER|RT,    16'h0000, 16'h0000, 16'h0040, 16'h0040, 1, 0, 0);
        // Wrap-around, and jump beating branch.
        cycle("jumpFFFF",   JP,       16'hFFFF, 16'h0000, 16'hFFFF, 16'h0040, 1, 0, 0);
        cycle("wrap",       7'b0,     16'h0000, 16'h0000, 16'h0000, 16'h0040, 1, 0, 0);
        cycle("br_and_jmp", BR|JP,    16'h1234, 16'h4321, 16'h1234, 16'h0040, 1, 0, 0);
        cycle("call800",    JP|CL,    16'h0800, 16'h0000, 16'h0800, 16'h0040, 0, 0, 0);

        // Reset asserted between edges, with a call and an exception still requested.
        #6;
        set_inputs(JP|CL|EX, 16'h0900, 16'h0000);
        push_exp("rst_async", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        push_exp("rst_hold", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        cycle("post_rst",   7'b0,     16'h0000, 16'h0000, 16'h0001, 16'h0000, 1, 0, 0);
        // A call without jump does nothing special.
        cycle("call_nojmp", CL,       16'h0A00, 16'h0000, 16'h0002, 16'h0000, 1, 0, 0);
        set_inputs(7'b0, 16'h0000, 16'h0000);

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pc_unit

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter WIDTH, default 16, PC and target width in bits.
REQ-002 Parameter INC, default 1, sequential increment added per fetch.
REQ-003 Parameter RESET_VEC, default 0x0000, PC value after reset.
REQ-004 Parameter EXC_VEC, default 0x0000, exception handler address.
REQ-005 Parameter RAS_DEPTH, default 4, return-address stack entries; power of two, at least 2.
REQ-006 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port stall, input, 1, hold PC and stack this cycle.
REQ-009 Port branch_taken, input, 1, redirect to branch_target.
REQ-010 Port branch_target, input, WIDTH, branch destination.
REQ-011 Port jump, input, 1, redirect to jump_target.
REQ-012 Port call, input, 1, jump to jump_target and push pc+INC; only valid with jump=1.
REQ-013 Port jump_target, input, WIDTH, jump or call destination.
REQ-014 Port ret, input, 1, pop stack top into PC.
REQ-015 Port exc_req, input, 1, take exception.
REQ-016 Port eret, input, 1, return from exception to epc.
REQ-017 Port pc, output, WIDTH, current program counter.
REQ-018 Port epc, output, WIDTH, saved exception PC.
REQ-019 Port ras_empty, output, 1, stack holds no entries.
REQ-020 Port ras_full, output, 1, stack holds RAS_DEPTH entries.
REQ-021 Port ras_err, output, 1, registered one-cycle pulse on ret with empty stack.

Function
REQ-022 Next-PC priority, highest first: exc_req, stall, eret, ret, jump/call, branch_taken, pc+INC.
REQ-023 exc_req: pc<=EXC_VEC and epc<=pc, even when stall=1; stack unchanged.
REQ-024 Stall without exc_req: pc, epc and stack hold; all other requests are ignored.
REQ-025 eret: pc<=epc; epc unchanged.
REQ-026 ret with a non-empty stack: pc<=top entry; stack pops one entry.
REQ-027 ret with an empty stack: pc<=EXC_VEC, epc<=pc, ras_err=1 next cycle; stack stays empty.
REQ-028 jump: pc<=jump_target; if call=1, also push pc+INC.
REQ-029 call while ras_full: push overwrites the oldest entry (circular); count stays RAS_DEPTH and ras_full stays 1.
REQ-030 call with jump=0 is ignored.
REQ-031 Only the highest-priority request acts; lower requests in the same cycle have no side effects, including pushes.
REQ-032 All PC arithmetic is modulo 2^WIDTH; pc+INC wraps from all-ones to the low values without a flag.
REQ-033 Latency: a redirect presented in cycle N is visible on pc in cycle N+1; pc is registered and there is no combinational input-to-pc path.
REQ-034 ras_empty and ras_full derive from the registered entry count.

Reset
REQ-035 On rst=1, asynchronously: pc=RESET_VEC, epc=RESET_VEC, stack count=0, ras_empty=1, ras_full=0, ras_err=0.
REQ-036 Stack entry contents are not reset and are don't-care when count=0.
REQ-037 Reset asserted mid-operation overrides all requests, including exc_req.
REQ-038 After rst deasserts, the first rising edge applies normal next-PC selection.

Structure
REQ-039 Shared package pc_pkg holds the next-PC select enumeration (SEL_EXC, SEL_HOLD, SEL_ERET, SEL_RET, SEL_JUMP, SEL_BR, SEL_SEQ) and the default parameter constants.
REQ-040 The return-address stack is a separate sub-module, pc_ras, with push, pop, top, empty and full.
REQ-041 pc_ras uses a circular buffer with a wrap-around pointer and a saturating count.

Verification
REQ-042 Reset, then 3 free cycles -> pc reads 0x0000, 0x0001, 0x0002, 0x0003.
REQ-043 pc=0x0010, call with jump_target=0x0100 -> pc=0x0100; ret three cycles later -> pc=0x0011 and ras_empty=1.
REQ-044 Five nested calls with RAS_DEPTH=4 -> ras_full=1 after the 4th call; five rets -> four correct addresses in LIFO order, then the 5th ret gives pc=EXC_VEC with a one-cycle ras_err pulse.
REQ-045 pc=0x0040 with stall=1 and exc_req=1 -> pc=EXC_VEC, epc=0x0040; eret -> pc=0x0040.
REQ-046 pc=0xFFFF with no request -> pc=0x0000; with branch_taken=1 and jump=1 together -> pc=jump_target.
REQ-047 rst asserted between clock edges during a call sequence -> pc=RESET_VEC and ras_empty=1 before the next edge.
